// File: rtl/comparador_8bits.sv
// comparador_8bits: registered signed/unsigned magnitude comparator with cascade inputs
//   clk, rst               : rising-edge clock, asynchronous active-high reset
//   in_valid               : sample A/B/signed_mode/cascade inputs this cycle
//   signed_mode            : 0 = unsigned, 1 = two's-complement compare
//   A, B                   : WIDTH-bit operands
//   casc_gt, casc_lt       : lower-slice result, used only when A == B
//   G, L, E                : registered one-hot greater/less/equal flags
//   out_valid              : flags were updated from a sample on the last edge
module comparador_8bits #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             casc_gt,
    input  logic             casc_lt,
    output logic             G,
    output logic             L,
    output logic             E,
    output logic             out_valid
);
    logic [WIDTH-1:0] a_k, b_k;
    logic             gt, lt, eq, g_n, l_n, e_n;
    // Inverting the sign bits maps two's-complement order onto unsigned order
    assign a_k = {A[WIDTH-1] ^ signed_mode, A[WIDTH-2:0]};
    assign b_k = {B[WIDTH-1] ^ signed_mode, B[WIDTH-2:0]};
    always_comb begin
        gt  = a_k > b_k;
        lt  = a_k < b_k;
        eq  = ~gt & ~lt;
        g_n = gt | (eq & casc_gt);
        l_n = lt | (eq & ~casc_gt & casc_lt);
        e_n = eq & ~casc_gt & ~casc_lt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            G         <= 1'b0;
            L         <= 1'b0;
            E         <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                G <= g_n;
                L <= l_n;
                E <= e_n;
            end
        end
    end
endmodule

// File: tb/tb_comparador_8bits.sv
// tb_comparador_8bits: randomized and directed self-checking bench for comparador_8bits
module tb_comparador_8bits;
    logic       clk = 1'b0;
    logic       rst, in_valid, signed_mode, casc_gt, casc_lt;
    logic [7:0] A, B;
    logic       G, L, E, out_valid;
    int         checks = 0;
    int         errors = 0;

    comparador_8bits #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .signed_mode(signed_mode),
        .A(A), .B(B), .casc_gt(casc_gt), .casc_lt(casc_lt),
        .G(G), .L(L), .E(E), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Reference: compare the operands as plain integers, then resolve ties by cascade
    function automatic logic [2:0] model(logic [7:0] a, logic [7:0] b, logic s, logic cg, logic cl);
        int va, vb;
        va = s ? int'($signed(a)) : int'(a);
        vb = s ? int'($signed(b)) : int'(b);
        if (va > vb) return 3'b100;
        if (va < vb) return 3'b010;
        if (cg) return 3'b100;
        if (cl) return 3'b010;
        return 3'b001;
    endfunction

    task automatic drive(logic [7:0] a, logic [7:0] b, logic s, logic cg, logic cl, logic v);
        A = a; B = b; signed_mode = s; casc_gt = cg; casc_lt = cl; in_valid = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({G, L, E, out_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_asserted: GLEV=%b expected 0000", {G, L, E, out_valid});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if ({G, L, E, out_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: GLEV=%b expected 0000", {G, L, E, out_valid});
        end
    endtask

    task automatic test_first_sample();
        drive(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checks++;
        if ({G, L, E, out_valid} !== 4'b0011) begin
            errors++;
            $display("FAIL first_sample: GLEV=%b expected 0011", {G, L, E, out_valid});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] av [4] = '{8'hFF, 8'hFF, 8'h80, 8'h80};
        logic [7:0] bv [4] = '{8'h80, 8'hFF, 8'hFF, 8'h80};
        logic [3:0] ex [4] = '{4'b1001, 4'b0011, 4'b0101, 4'b0011};
        for (int i = 0; i < 4; i++) begin
            drive(av[i], bv[i], 1'b0, 1'b0, 1'b0, 1'b1);
            step();
            checks++;
            if ({G, L, E, out_valid} !== ex[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: GLEV=%b expected %b", i, {G, L, E, out_valid}, ex[i]);
            end
        end
    endtask

    task automatic test_signed();
        logic [7:0] av [6] = '{8'h80, 8'h80, 8'hFF, 8'h00, 8'h80, 8'h00};
        logic [7:0] bv [6] = '{8'h7F, 8'h7F, 8'h00, 8'hFF, 8'hFF, 8'hFF};
        logic       sv [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] ex [6] = '{3'b100, 3'b010, 3'b010, 3'b100, 3'b010, 3'b010};
        for (int i = 0; i < 6; i++) begin
            drive(av[i], bv[i], sv[i], 1'b0, 1'b0, 1'b1);
            step();
            checks++;
            if ({G, L, E, out_valid} !== {ex[i], 1'b1}) begin
                errors++;
                $display("FAIL signed[%0d]: GLEV=%b expected %b1", i, {G, L, E, out_valid}, ex[i]);
            end
        end
    endtask

    task automatic test_cascade();
        logic [7:0] av [5] = '{8'h3C, 8'h3C, 8'h3C, 8'h3D, 8'h3C};
        logic       gv [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       lv [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] bv [5] = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3D};
        logic [2:0] ex [5] = '{3'b100, 3'b010, 3'b100, 3'b100, 3'b010};
        for (int i = 0; i < 5; i++) begin
            drive(av[i], bv[i], 1'b0, gv[i], lv[i], 1'b1);
            step();
            checks++;
            if ({G, L, E, out_valid} !== {ex[i], 1'b1}) begin
                errors++;
                $display("FAIL cascade[%0d]: GLEV=%b expected %b1", i, {G, L, E, out_valid}, ex[i]);
            end
        end
    endtask

    task automatic test_hold();
        drive(8'h10, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(8'(i), 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
            step();
            checks++;
            if ({G, L, E, out_valid} !== 4'b1000) begin
                errors++;
                $display("FAIL hold[%0d]: GLEV=%b expected 1000", i, {G, L, E, out_valid});
            end
        end
    endtask

    task automatic test_async_reset();
        drive(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checks++;
        if ({G, L, E, out_valid} !== 4'b0101) begin
            errors++;
            $display("FAIL pre_reset: GLEV=%b expected 0101", {G, L, E, out_valid});
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({G, L, E, out_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: GLEV=%b expected 0000 at t=%0t", {G, L, E, out_valid}, $time);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checks++;
        if ({G, L, E, out_valid} !== 4'b0011) begin
            errors++;
            $display("FAIL post_reset: GLEV=%b expected 0011", {G, L, E, out_valid});
        end
    endtask

    task automatic test_random();
        logic [2:0] ex = 3'b001;
        logic [7:0] a, b;
        logic       v;
        for (int i = 0; i < 400; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
            v = ($urandom_range(0, 3) != 0);
            drive(a, b, 1'($urandom), 1'($urandom), 1'($urandom), v);
            if (v) ex = model(a, b, signed_mode, casc_gt, casc_lt);
            step();
            checks++;
            if ({G, L, E, out_valid} !== {ex, v}) begin
                errors++;
                $display("FAIL random[%0d] A=%h B=%h s=%b cg=%b cl=%b v=%b: GLEV=%b expected %b%b",
                         i, A, B, signed_mode, casc_gt, casc_lt, v, {G, L, E, out_valid}, ex, v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_back_to_back();
        test_signed();
        test_cascade();
        test_hold();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
